outer_acc_ctrl: RTL and testbench
=================================

OUTER_ACC_CTRL -- requirements
Module: outer_acc_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_LEN, 32, element width; M, 8, rows of C; N, 8, columns of C; K, 8, maximum outer-product steps per job; ROW_SIZE, DATA_LEN*N, packed vector width; MAT_SIZE, DATA_LEN*M*N, packed matrix width.
REQ-002 i_clk  input  1  clock; i_rstn  input  1  reset, asynchronous, active-low.
REQ-003 i_start  input  1  job start request, sampled only in IDLE.
REQ-004 i_k_len  input  $clog2(K+1)  number of steps for the job, latched on accepted start.
REQ-005 o_busy  output  1  high in every state other than IDLE.
REQ-006 o_done  output  1  one-cycle pulse when the job result is final.
REQ-007 o_rd_req  output  1  operand fetch request, level.
REQ-008 o_rd_idx  output  $clog2(K)  step index being fetched.
REQ-009 i_rd_valid  input  1  operand beat present, accepted only while o_rd_req is high.
REQ-010 i_col_a, i_row_b  input  ROW_SIZE each  column of A and row of B for step o_rd_idx.
REQ-011 o_vec_at, o_vec_b  output  ROW_SIZE each  operands driven to the outer-product datapath.
REQ-012 i_mat_c  input  MAT_SIZE  datapath product matrix, 2-cycle registered latency.
REQ-013 o_mat_acc  output  MAT_SIZE  accumulated C matrix, element (r,c) at bits DATA_LEN*(N*r+c).
REQ-014 o_acc_valid  output  1  o_mat_acc holds a completed job result.

Function
REQ-015 The FSM SHALL have four states: IDLE, FETCH, DRAIN and DONE.
REQ-016 IDLE->FETCH SHALL occur on i_start=1 with i_k_len>=1; on accept, o_mat_acc is cleared to 0, o_acc_valid is cleared, and the step and beat counters are cleared.
REQ-017 i_start with i_k_len=0 SHALL go IDLE->DONE directly, with o_mat_acc cleared to 0 and no fetch issued.
REQ-018 i_k_len>K SHALL be saturated to K.
REQ-019 In FETCH, o_rd_req SHALL be 1 and o_rd_idx SHALL equal the number of beats accepted so far.
REQ-020 A beat SHALL be accepted on a clock edge where o_rd_req=1 and i_rd_valid=1; i_rd_valid outside FETCH SHALL be ignored.
REQ-021 o_vec_at/o_vec_b SHALL equal i_col_a/i_row_b combinationally in an accepting cycle, and all-zero otherwise.
REQ-022 A 2-stage valid shift register SHALL track accepted beats; i_mat_c SHALL be added element-wise into o_mat_acc on each edge where stage 2 is set.
REQ-023 Accumulation SHALL be DATA_LEN-bit signed two's complement with silent wrap-around and no saturation.
REQ-024 FETCH->DRAIN SHALL occur on the edge that accepts beat i_k_len-1; o_rd_req SHALL be 0 in DRAIN.
REQ-025 DRAIN->DONE SHALL occur on the edge that performs the final accumulation (valid pipeline empty after it).
REQ-026 DONE SHALL last one cycle with o_done=1, then go to IDLE and set o_acc_valid=1.
REQ-027 o_mat_acc and o_acc_valid SHALL hold until the next accepted start.
REQ-028 Latency: if the last beat is accepted on edge t, o_done SHALL be high in the cycle following edge t+2.
REQ-029 i_start while o_busy=1 SHALL be ignored, with no effect on the running job.
REQ-030 Bubbles (i_rd_valid=0) in FETCH SHALL stall o_rd_idx without corrupting the valid pipeline.

Reset
REQ-031 Asserting i_rstn low SHALL immediately force: state IDLE, o_busy=0, o_done=0, o_rd_req=0, o_rd_idx=0, o_acc_valid=0, o_mat_acc=0, valid pipeline cleared.
REQ-032 Reset asserted mid-job SHALL abort the job; after release, no stale accumulation from in-flight beats SHALL occur.

Structure
REQ-033 DATA_LEN, M, N, K, ROW_SIZE, MAT_SIZE and the FSM state encoding SHALL live in a shared package spmv_pkg.
REQ-034 One sub-module SHALL be used: mat_acc_add, the registered MAT_SIZE element-wise accumulator with clear and enable; the outer-product datapath is instantiated by the parent, not inside this block.

Verification
REQ-035 i_k_len=1, a=all 2, b=all 3, product model returns 6 -> o_mat_acc all 6, o_done 3 cycles after the accepting cycle.
REQ-036 i_k_len=8, back-to-back beats with a[r]=r, b[c]=1 -> element (r,c)=8r, o_rd_idx sequence 0..7.
REQ-037 i_k_len=4 with i_rd_valid low on alternate cycles -> same result as the bubble-free run, o_rd_idx holds during bubbles.
REQ-038 Products of 0x7FFFFFFF accumulated twice -> element wraps to 0xFFFFFFFE.
REQ-039 i_start pulsed mid-job -> ignored; i_k_len=0 -> o_done after one cycle with o_mat_acc=0.
REQ-040 i_rstn low during DRAIN -> all outputs 0 immediately; a fresh job after release gives a correct, uncontaminated result.

Source files
------------

// File: rtl/spmv_pkg.sv
// Shared constants and FSM encoding for the outer-product accumulate controller.
//   DATA_LEN  element width
//   M, N      rows / columns of the C matrix
//   K         maximum outer-product steps per job
//   ROW_SIZE  packed vector width (one column of A or row of B)
//   MAT_SIZE  packed matrix width, element (r,c) at DATA_LEN*(N*r+c)
package spmv_pkg;

    localparam int DATA_LEN = 32;
    localparam int M        = 8;
    localparam int N        = 8;
    localparam int K        = 8;
    localparam int ROW_SIZE = DATA_LEN * N;
    localparam int MAT_SIZE = DATA_LEN * M * N;
    localparam int KLEN_W   = $clog2(K + 1);
    localparam int IDX_W    = $clog2(K);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/outer_acc_ctrl_if.sv
// Operand fetch channel between the accumulate controller and the operand store.
//   rd_req    controller -> store  fetch request (level)
//   rd_idx    controller -> store  step index being fetched
//   rd_valid  store -> controller  operand beat present
//   col_a     store -> controller  column of A for step rd_idx
//   row_b     store -> controller  row of B for step rd_idx
interface outer_acc_ctrl_if #(
    parameter int ROW_SIZE = spmv_pkg::ROW_SIZE,
    parameter int IDX_W    = spmv_pkg::IDX_W
);

    logic                rd_req;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_valid;
    logic [ROW_SIZE-1:0] col_a;
    logic [ROW_SIZE-1:0] row_b;

    modport master (
        output rd_req,
        output rd_idx,
        input  rd_valid,
        input  col_a,
        input  row_b
    );

    modport slave (
        input  rd_req,
        input  rd_idx,
        output rd_valid,
        output col_a,
        output row_b
    );

endinterface

// File: rtl/mat_acc_add.sv
// Registered element-wise matrix accumulator.
//   i_clk, i_rstn  clock, async active-low reset (clears the matrix)
//   i_clr          synchronous clear, wins over i_en
//   i_en           add i_mat_c into the accumulator this edge
//   i_mat_c        addend matrix
//   o_mat_acc      accumulated matrix; each element wraps at DATA_LEN bits
module mat_acc_add #(
    parameter int DATA_LEN = spmv_pkg::DATA_LEN,
    parameter int ELEMS    = spmv_pkg::M * spmv_pkg::N
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic [DATA_LEN*ELEMS-1:0] i_mat_c,
    output logic [DATA_LEN*ELEMS-1:0] o_mat_acc
);

    logic [DATA_LEN*ELEMS-1:0] acc;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc <= '0;
        end else if (i_clr) begin
            acc <= '0;
        end else if (i_en) begin
            // two's complement add; overflow wraps silently
            for (int e = 0; e < ELEMS; e++) begin
                acc[e*DATA_LEN +: DATA_LEN] <= acc[e*DATA_LEN +: DATA_LEN]
                                             + i_mat_c[e*DATA_LEN +: DATA_LEN];
            end
        end
    end

    assign o_mat_acc = acc;

endmodule

// File: rtl/outer_acc_ctrl.sv
// Outer-product accumulate controller: fetches i_k_len operand pairs, feeds
// them to an external outer-product datapath (2-cycle registered latency) and
// accumulates the returned product matrices into o_mat_acc.
//   i_clk, i_rstn     clock, async active-low reset
//   i_start, i_k_len  job start (sampled in IDLE) and step count (saturated to K)
//   o_busy, o_done    not-IDLE flag, one-cycle completion pulse
//   rd                operand fetch channel (master side)
//   o_vec_at, o_vec_b operands to the datapath, zero outside accepting cycles
//   i_mat_c           datapath product matrix
//   o_mat_acc         accumulated result, o_acc_valid marks it final
//
// state | meaning
// IDLE  | waiting for a start request
// FETCH | requesting operand beats, one per step
// DRAIN | all beats taken, waiting for the product pipeline to empty
// DONE  | result final, o_done pulse
module outer_acc_ctrl #(
    parameter int DATA_LEN = spmv_pkg::DATA_LEN,
    parameter int M        = spmv_pkg::M,
    parameter int N        = spmv_pkg::N,
    parameter int K        = spmv_pkg::K,
    parameter int ROW_SIZE = DATA_LEN * N,
    parameter int MAT_SIZE = DATA_LEN * M * N
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [$clog2(K+1)-1:0]   i_k_len,
    output logic                     o_busy,
    output logic                     o_done,
    outer_acc_ctrl_if.master         rd,
    output logic [ROW_SIZE-1:0]      o_vec_at,
    output logic [ROW_SIZE-1:0]      o_vec_b,
    input  logic [MAT_SIZE-1:0]      i_mat_c,
    output logic [MAT_SIZE-1:0]      o_mat_acc,
    output logic                     o_acc_valid
);

    import spmv_pkg::*;

    localparam int KW = $clog2(K + 1);
    localparam int IW = $clog2(K);

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_sat;
    logic [KW-1:0] beat_cnt;
    logic [1:0]    vld_q;
    logic          start_ok;
    logic          accept;
    logic          last_beat;
    logic          final_acc;

    assign k_sat     = (i_k_len > KW'(K)) ? KW'(K) : i_k_len;
    assign start_ok  = (state == IDLE) && i_start;
    assign accept    = (state == FETCH) && rd.rd_valid;
    assign last_beat = accept && (beat_cnt == k_len_q - KW'(1));
    // stage 2 adds this edge and nothing is left behind it
    assign final_acc = vld_q[1] && !vld_q[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = (k_sat == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (final_acc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            k_len_q     <= '0;
            beat_cnt    <= '0;
            vld_q       <= '0;
            o_acc_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= {vld_q[0], accept};
            if (start_ok) begin
                k_len_q     <= k_sat;
                beat_cnt    <= '0;
                o_acc_valid <= 1'b0;
            end else begin
                if (accept) begin
                    beat_cnt <= beat_cnt + KW'(1);
                end
                if (state == DONE) begin
                    o_acc_valid <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);
    assign rd.rd_req = (state == FETCH);
    assign rd.rd_idx = beat_cnt[IW-1:0];
    assign o_vec_at  = accept ? rd.col_a : '0;
    assign o_vec_b   = accept ? rd.row_b : '0;

    mat_acc_add #(
        .DATA_LEN (DATA_LEN),
        .ELEMS    (M * N)
    ) u_acc (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (start_ok),
        .i_en      (vld_q[1]),
        .i_mat_c   (i_mat_c),
        .o_mat_acc (o_mat_acc)
    );

endmodule

// File: tb/tb_outer_acc_ctrl.sv
// Scoreboard bench for outer_acc_ctrl with a 2-cycle outer-product datapath model.
module tb_outer_acc_ctrl;
    import spmv_pkg::*;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic [KLEN_W-1:0]   k_len = '0;
    logic                busy, done, acc_valid;
    logic [ROW_SIZE-1:0] vec_at, vec_b;
    logic [MAT_SIZE-1:0] mat_c, mat_acc;
    logic [ROW_SIZE-1:0] s1_a, s1_b;

    outer_acc_ctrl_if rd_bus ();

    outer_acc_ctrl dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_k_len     (k_len),
        .o_busy      (busy),
        .o_done      (done),
        .rd          (rd_bus),
        .o_vec_at    (vec_at),
        .o_vec_b     (vec_b),
        .i_mat_c     (mat_c),
        .o_mat_acc   (mat_acc),
        .o_acc_valid (acc_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_start_cyc = 0;

    logic [MAT_SIZE-1:0] res_q[$];
    int                  lat_q[$];
    bit                  ref_q[$];
    logic [IDX_W-1:0]    idx_q[$];
    logic [MAT_SIZE-1:0] last_exp = '0;
    bit                  chk_after = 1'b0;

    function automatic logic [ROW_SIZE-1:0] vconst(input logic [DATA_LEN-1:0] v);
        logic [ROW_SIZE-1:0] r;
        for (int i = 0; i < N; i++) r[i*DATA_LEN +: DATA_LEN] = v;
        return r;
    endfunction

    function automatic logic [ROW_SIZE-1:0] vramp(input int off);
        logic [ROW_SIZE-1:0] r;
        for (int i = 0; i < N; i++) r[i*DATA_LEN +: DATA_LEN] = DATA_LEN'(i + off);
        return r;
    endfunction

    function automatic logic [MAT_SIZE-1:0] outer(input logic [ROW_SIZE-1:0] a,
                                                  input logic [ROW_SIZE-1:0] b,
                                                  input int k);
        logic [MAT_SIZE-1:0] m;
        logic [DATA_LEN-1:0] p;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                p = a[r*DATA_LEN +: DATA_LEN] * b[c*DATA_LEN +: DATA_LEN] * DATA_LEN'(k);
                m[DATA_LEN*(N*r+c) +: DATA_LEN] = p;
            end
        return m;
    endfunction

    // outer-product datapath: operand register, then product register
    always @(posedge clk) begin
        s1_a  <= vec_at;
        s1_b  <= vec_b;
        mat_c <= outer(s1_a, s1_b, 1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_mat(input string name, input logic [MAT_SIZE-1:0] act,
                             input logic [MAT_SIZE-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            for (int e = 0; e < M*N; e++)
                if (act[e*DATA_LEN +: DATA_LEN] !== exp[e*DATA_LEN +: DATA_LEN]) begin
                    $display("FAIL %s: element %0d got %h want %h", name, e,
                             act[e*DATA_LEN +: DATA_LEN], exp[e*DATA_LEN +: DATA_LEN]);
                    break;
                end
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_rd_req"}, rd_bus.rd_req, 0);
        check_val({tag, "_rd_idx"}, rd_bus.rd_idx, 0);
        check_val({tag, "_acc_valid"}, acc_valid, 0);
        check_mat({tag, "_mat_acc"}, mat_acc, '0);
    endtask

    // monitor: pops expectations whenever the DUT takes a beat or signals done
    always @(negedge clk) begin
        if (rstn) begin
            if (chk_after) begin
                chk_after = 1'b0;
                check_val("acc_valid_after_done", acc_valid, 1);
                check_val("busy_after_done", busy, 0);
                check_mat("mat_hold_after_done", mat_acc, last_exp);
            end
            if (start && !busy) last_start_cyc = cyc;
            if (rd_bus.rd_req && rd_bus.rd_valid) begin
                if (idx_q.size() == 0) begin
                    check_val("unexpected_beat", 1, 0);
                end else begin
                    check_val("rd_idx", rd_bus.rd_idx, idx_q.pop_front());
                    check_mat("vec_at", MAT_SIZE'(vec_at), MAT_SIZE'(rd_bus.col_a));
                    check_mat("vec_b", MAT_SIZE'(vec_b), MAT_SIZE'(rd_bus.row_b));
                end
                last_acc_cyc = cyc;
            end else begin
                if (rd_bus.rd_req && idx_q.size() != 0)
                    check_val("rd_idx_stall", rd_bus.rd_idx, idx_q[0]);
                check_mat("vec_idle_zero", MAT_SIZE'({vec_at, vec_b}), '0);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check_val("unexpected_done", 1, 0);
                end else begin
                    last_exp = res_q.pop_front();
                    check_mat("result", mat_acc, last_exp);
                    check_val("latency", cyc - (ref_q.pop_front() ? last_start_cyc : last_acc_cyc),
                              lat_q.pop_front());
                    check_val("acc_valid_at_done", acc_valid, 0);
                    chk_after = 1'b1;
                end
            end
        end
    end

    task automatic run_job(input int k_req, input int k_eff,
                           input logic [ROW_SIZE-1:0] a, input logic [ROW_SIZE-1:0] b,
                           input bit bubbles, input bit mid_start, input bit abort);
        int cnt = 0;
        int guard = 0;
        bit pulsed = 1'b0;
        if (!abort) begin
            res_q.push_back(outer(a, b, k_eff));
            lat_q.push_back(k_eff == 0 ? 1 : 3);
            ref_q.push_back(k_eff == 0);
        end
        for (int i = 0; i < k_eff; i++) idx_q.push_back(IDX_W'(i));
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KLEN_W'(k_req);
        rd_bus.col_a = a;
        rd_bus.row_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        k_len = '0;
        while (cnt < k_eff && guard < 200) begin
            rd_bus.rd_valid = !bubbles || guard[0];
            start = mid_start && cnt == 1 && !pulsed;
            if (start) pulsed = 1'b1;
            #1;
            if (rd_bus.rd_req && rd_bus.rd_valid) cnt++;
            @(posedge clk); #1;
            guard++;
        end
        rd_bus.rd_valid = 1'b0;
        start = 1'b0;
        check_val("beats_taken", cnt, k_eff);
        if (abort) begin
            #1 rstn = 1'b0;
            #1 check_zero("abort");
            @(posedge clk); #1 rstn = 1'b1;
            repeat (4) @(posedge clk);
            #1 check_zero("post_abort");
            return;
        end
        guard = 0;
        while (!done && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("done_seen", done, 1);
        if (!done) begin
            rstn = 1'b0;
            #1 rstn = 1'b1;
            res_q.delete(); lat_q.delete(); ref_q.delete(); idx_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rd_bus.rd_valid = 1'b0;
        rd_bus.col_a = '0;
        rd_bus.row_b = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // operand beats offered while idle must be ignored
        rd_bus.rd_valid = 1'b1;
        rd_bus.col_a = vconst(9);
        rd_bus.row_b = vconst(9);
        repeat (3) @(posedge clk);
        #1 rd_bus.rd_valid = 1'b0;
        check_val("idle_not_busy", busy, 0);

        run_job(1, 1, vconst(2), vconst(3), 0, 0, 0);
        check_val("k1_elem_3_5", mat_acc[DATA_LEN*(N*3+5) +: DATA_LEN], 6);

        run_job(8, 8, vramp(0), vconst(1), 0, 0, 0);
        check_val("k8_elem_7_0", mat_acc[DATA_LEN*(N*7) +: DATA_LEN], 56);

        run_job(4, 4, vramp(1), vramp(0), 1, 0, 0);
        check_val("bubble_elem_2_5", mat_acc[DATA_LEN*(N*2+5) +: DATA_LEN], 60);

        run_job(2, 2, vconst(32'h7FFF_FFFF), vconst(1), 0, 0, 0);
        check_val("wrap_elem_0_0", mat_acc[0 +: DATA_LEN], 64'hFFFF_FFFE);

        run_job(3, 3, vconst(4), vramp(2), 0, 1, 0);
        run_job(0, 0, vconst(5), vconst(5), 0, 0, 0);
        run_job(12, 8, vconst(1), vramp(0), 0, 0, 0);
        check_val("sat_elem_4_3", mat_acc[DATA_LEN*(N*4+3) +: DATA_LEN], 24);

        run_job(3, 3, vconst(7), vconst(7), 0, 0, 1);
        run_job(2, 2, vconst(1), vconst(5), 0, 0, 0);
        check_val("fresh_elem_6_6", mat_acc[DATA_LEN*(N*6+6) +: DATA_LEN], 10);

        check_val("res_q_drained", res_q.size(), 0);
        check_val("idx_q_drained", idx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
